// File: rtl/fir_mac_scheduler.sv
// -----------------------------------------------------------------------------
// fir_mac_scheduler
//
// Time-multiplexed FIR sequencer for the stereo voice-effect path. One external
// LANES-wide signed dot-product unit is shared between the left and right
// channels with round-robin arbitration. Each channel owns a TAPS-deep delay
// line (tap 0 = newest sample). For every accepted sample the block issues
// PASSES windows of LANES taps, accumulates the pipelined partial sums, then
// rounds (half up) and saturates the result to a WIDTH-bit output sample.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   l_valid/l_data/l_ready  left sample handshake (accept = valid & ready)
//   r_valid/r_data/r_ready  right sample handshake
//   coef_addr             pass index into the external coefficient bank
//   coef_data             coefficients for coef_addr (combinational read)
//   mac_a                 sample window, lane j = tap coef_addr*LANES+j
//   mac_b                 coef_data passed straight through
//   mac_ce                dot-product clock enable (high only while running)
//   mac_p                 dot-product result, MAC_LAT ce-cycles after inputs
//   out_valid             one-cycle pulse, output sample valid
//   out_chan              0 = left, 1 = right
//   out_data              filtered, rounded, saturated sample
//   busy                  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module fir_mac_scheduler #(
    parameter int  WIDTH   = 16,
    parameter int  LANES   = 20,
    parameter int  PASSES  = 4,
    parameter int  MAC_LAT = 6,
    parameter int  P_W     = 37,
    parameter int  ACC_W   = 40,
    parameter int  SHIFT   = 15,
    localparam int CA_W    = (PASSES > 1) ? $clog2(PASSES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   l_valid,
    input  logic [WIDTH-1:0]       l_data,
    output logic                   l_ready,
    input  logic                   r_valid,
    input  logic [WIDTH-1:0]       r_data,
    output logic                   r_ready,
    output logic [CA_W-1:0]        coef_addr,
    input  logic [LANES*WIDTH-1:0] coef_data,
    output logic [LANES*WIDTH-1:0] mac_a,
    output logic [LANES*WIDTH-1:0] mac_b,
    output logic                   mac_ce,
    input  logic [P_W-1:0]         mac_p,
    output logic                   out_valid,
    output logic                   out_chan,
    output logic [WIDTH-1:0]       out_data,
    output logic                   busy
);

    localparam int TAPS   = LANES * PASSES;
    localparam int TAP_IW = $clog2(TAPS);
    localparam int CNT_W  = $clog2(PASSES + MAC_LAT);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PASSES + MAC_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_PASSES = CNT_W'(PASSES);
    localparam logic [CNT_W-1:0] CNT_ACC    = CNT_W'(MAC_LAT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(64'sd1 <<< (WIDTH - 1)));

    logic [1:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic                    chan;      // channel being filtered
    logic                    ptr;       // round-robin preference, 0 = left
    logic signed [ACC_W-1:0] acc;

    logic [WIDTH-1:0] line_l [TAPS];
    logic [WIDTH-1:0] line_r [TAPS];

    logic                    idle;
    logic                    pick_r;
    logic signed [ACC_W-1:0] p_ext;
    logic signed [ACC_W-1:0] rounded;
    logic [WIDTH-1:0]        sat_data;

    // ------------------------------------------------------------------
    // Arbitration: a lone requester wins; on a tie the pointer decides.
    // pick_r implies r_valid, so at most one ready is ever high.
    // ------------------------------------------------------------------
    assign idle    = (state == S_IDLE);
    assign pick_r  = r_valid && (!l_valid || ptr);
    assign l_ready = idle && l_valid && !pick_r;
    assign r_ready = idle && pick_r;

    assign busy   = !idle;
    assign mac_ce = (state == S_RUN);
    assign mac_b  = coef_data;

    // ------------------------------------------------------------------
    // Tap window for the current pass; zero once all passes are issued.
    // ------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        coef_addr = '0;
        mac_a     = '0;
        if (state == S_RUN && cnt < CNT_PASSES) begin
            coef_addr = cnt[CA_W-1:0];
            for (int j = 0; j < LANES; j++) begin
                mac_a[j*WIDTH +: WIDTH] = chan
                    ? line_r[TAP_IW'(int'(coef_addr) * LANES + j)]
                    : line_l[TAP_IW'(int'(coef_addr) * LANES + j)];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output arithmetic: round half up, arithmetic shift, saturate.
    // ------------------------------------------------------------------
    assign p_ext   = {{(ACC_W - P_W){mac_p[P_W-1]}}, mac_p};
    assign rounded = (acc + RND) >>> SHIFT;

    always_comb begin
        sat_data = WIDTH'(rounded);
        if (rounded > OUT_MAX) begin
            sat_data = WIDTH'(OUT_MAX);
        end else if (rounded < OUT_MIN) begin
            sat_data = WIDTH'(OUT_MIN);
        end
    end

    // ------------------------------------------------------------------
    // Delay lines: only the accepted channel shifts.
    // ------------------------------------------------------------------
    // NOTE: the delay lines are memories but are cleared on reset on purpose:
    // a filtered output after reset must carry no residue of old samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                line_l[i] <= '0;
                line_r[i] <= '0;
            end
        end else if (l_ready) begin
            for (int i = TAPS - 1; i > 0; i--) begin
                line_l[i] <= line_l[i-1];
            end
            line_l[0] <= l_data;
        end else if (r_ready) begin
            for (int i = TAPS - 1; i > 0; i--) begin
                line_r[i] <= line_r[i-1];
            end
            line_r[0] <= r_data;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer. RUN issues PASSES windows at cnt 0..PASSES-1; their
    // results arrive MAC_LAT cycles later, i.e. during cnt MAC_LAT..last.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            chan      <= 1'b0;
            ptr       <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_chan  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (l_ready || r_ready) begin
                        chan  <= r_ready;
                        ptr   <= !r_ready;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt >= CNT_ACC) begin
                        acc <= acc + p_ext;
                    end
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= S_OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    out_valid <= 1'b1;
                    out_chan  <= chan;
                    out_data  <= sat_data;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_scheduler
//
// Self-checking bench. Provides the external coefficient bank and a pipelined
// dot-product unit, keeps its own copy of both delay lines, and pushes the
// expected {channel, sample, arrival cycle} into a scoreboard on each accept.
// The monitor pops and compares on every out_valid.
// -----------------------------------------------------------------------------
module tb_fir_mac_scheduler;

    localparam int WIDTH   = 16;
    localparam int LANES   = 20;
    localparam int PASSES  = 4;
    localparam int MAC_LAT = 6;
    localparam int P_W     = 37;
    localparam int ACC_W   = 40;
    localparam int SHIFT   = 15;
    localparam int TAPS    = LANES * PASSES;
    localparam int TAP_IW  = $clog2(TAPS);
    localparam int LAT     = PASSES + MAC_LAT + 2;

    logic                   clk     = 1'b0;
    logic                   rst     = 1'b1;
    logic                   l_valid = 1'b0;
    logic [WIDTH-1:0]       l_data  = '0;
    logic                   l_ready;
    logic                   r_valid = 1'b0;
    logic [WIDTH-1:0]       r_data  = '0;
    logic                   r_ready;
    logic [1:0]             coef_addr;
    logic [LANES*WIDTH-1:0] coef_data;
    logic [LANES*WIDTH-1:0] mac_a;
    logic [LANES*WIDTH-1:0] mac_b;
    logic                   mac_ce;
    logic [P_W-1:0]         mac_p;
    logic                   out_valid;
    logic                   out_chan;
    logic [WIDTH-1:0]       out_data;
    logic                   busy;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    fir_mac_scheduler #(
        .WIDTH(WIDTH), .LANES(LANES), .PASSES(PASSES), .MAC_LAT(MAC_LAT),
        .P_W(P_W), .ACC_W(ACC_W), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst),
        .l_valid(l_valid), .l_data(l_data), .l_ready(l_ready),
        .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
        .coef_addr(coef_addr), .coef_data(coef_data),
        .mac_a(mac_a), .mac_b(mac_b), .mac_ce(mac_ce), .mac_p(mac_p),
        .out_valid(out_valid), .out_chan(out_chan), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- external coefficient bank ----------------
    logic signed [WIDTH-1:0] coef_mem [TAPS];

    always_comb begin
        coef_data = '0;
        for (int j = 0; j < LANES; j++) begin
            coef_data[j*WIDTH +: WIDTH] = coef_mem[TAP_IW'(int'(coef_addr) * LANES + j)];
        end
    end

    // ---------------- external dot-product unit ----------------
    longint pipe [MAC_LAT];

    initial begin
        for (int k = 0; k < MAC_LAT; k++) pipe[k] = 0;
    end

    always @(posedge clk) begin : dot_product
        longint s;
        if (mac_ce) begin
            s = 0;
            for (int j = 0; j < LANES; j++) begin
                s += longint'($signed(mac_a[j*WIDTH +: WIDTH])) *
                     longint'($signed(mac_b[j*WIDTH +: WIDTH]));
            end
            for (int k = MAC_LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= s;
        end
    end

    assign mac_p = P_W'(pipe[MAC_LAT-1]);

    // ---------------- reference model and scoreboard ----------------
    typedef struct { int chan; int data; longint cyc; } exp_t;
    typedef struct { int chan; int data; } obs_t;
    typedef struct { int chan; longint cyc; } acc_t;

    exp_t sb[$];
    obs_t obs_q[$];
    acc_t acc_log[$];
    int   m_line [2][TAPS];

    function automatic int expect_out(int ch);
        longint a = 0;
        longint r;
        for (int k = 0; k < TAPS; k++) a += longint'(m_line[ch][k]) * longint'(coef_mem[k]);
        r = (a + 64'sd16384) >>> 15;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    function automatic void accept(int ch, int d);
        for (int k = TAPS - 1; k > 0; k--) m_line[ch][k] = m_line[ch][k-1];
        m_line[ch][0] = d;
        sb.push_back('{ch, expect_out(ch), cyc + LAT});
        acc_log.push_back('{ch, cyc});
    endfunction

    function automatic void clear_model();
        sb.delete();
        obs_q.delete();
        acc_log.delete();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < TAPS; k++) m_line[c][k] = 0;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (out_valid === 1'b1) begin
                obs_q.push_back('{int'(out_chan), int'($signed(out_data))});
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: out_valid chan=%0d data=%0d at cycle %0d, expected no output",
                             out_chan, $signed(out_data), cyc);
                end else begin
                    e = sb.pop_front();
                    if (out_chan !== 1'(e.chan) || out_data !== WIDTH'(e.data) || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL sb_output: got chan=%0d data=%0d cycle=%0d, expected chan=%0d data=%0d cycle=%0d",
                                 out_chan, $signed(out_data), cyc, e.chan, e.data, e.cyc);
                    end
                end
            end
            if (l_ready === 1'b1 || r_ready === 1'b1) begin
                n_checks++;
                if (l_ready === 1'b1 && r_ready === 1'b1) begin
                    n_fail++;
                    $display("FAIL one_grant: l_ready=1 r_ready=1 at cycle %0d, expected at most one", cyc);
                end
            end
            if (l_valid && l_ready === 1'b1) accept(0, int'($signed(l_data)));
            if (r_valid && r_ready === 1'b1) accept(1, int'($signed(r_data)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        clear_model();
        rst = 1'b0;
    endtask

    task automatic send(int ch, int d);
        bit done = 1'b0;
        if (ch == 0) begin l_valid = 1'b1; l_data = WIDTH'(d); end
        else         begin r_valid = 1'b1; r_data = WIDTH'(d); end
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (ch == 0) ? (l_ready === 1'b1) : (r_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        if (ch == 0) l_valid = 1'b0;
        else         r_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_timeout: chan %0d sample %0d not accepted, expected accept within 200 cycles", ch, d);
        end
    endtask

    task automatic wait_idle(string what);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = (sb.size() == 0) && (busy === 1'b0);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_drain: %0d outputs pending busy=%b, expected all delivered and idle",
                     what, sb.size(), busy);
        end
        tick();
    endtask

    task automatic set_coefs(int mode);
        for (int k = 0; k < TAPS; k++) begin
            case (mode)
                0:       coef_mem[k] = (k == 0) ? 16'sd32767 : 16'sd0;
                1:       coef_mem[k] = WIDTH'(k + 1);
                2:       coef_mem[k] = 16'sd32767;
                default: coef_mem[k] = (k == 0) ? 16'sd32767 : ((k == 1) ? 16'sd16384 : 16'sd0);
            endcase
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_chan, mac_ce, busy, l_ready, r_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: {out_valid,out_chan,mac_ce,busy,l_ready,r_ready}=%b, expected 000000",
                     {out_valid, out_chan, mac_ce, busy, l_ready, r_ready});
        end
        n_checks++;
        if (out_data !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_out_data: got %h, expected 0000", out_data);
        end
        n_checks++;
        if (coef_addr !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_coef_addr: got %0d, expected 0", coef_addr);
        end
        tick();
        clear_model();
        rst = 1'b0;
    endtask

    task automatic test_impulse();
        set_coefs(0);
        send(0, 16384);
        @(negedge clk);   // first RUN cycle, cnt 0
        n_checks++;
        if (busy !== 1'b1 || mac_ce !== 1'b1 || coef_addr !== 2'd0 || mac_a[15:0] !== 16'd16384) begin
            n_fail++;
            $display("FAIL run_cnt0: busy=%b mac_ce=%b coef_addr=%0d lane0=%0d, expected 1 1 0 16384",
                     busy, mac_ce, coef_addr, mac_a[15:0]);
        end
        @(negedge clk);   // cnt 1
        n_checks++;
        if (coef_addr !== 2'd1) begin
            n_fail++;
            $display("FAIL run_cnt1_addr: got %0d, expected 1", coef_addr);
        end
        tick();
        wait_idle("impulse");
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0].chan != 0 || obs_q[0].data != 16384) begin
            n_fail++;
            $display("FAIL impulse_value: got %0d outputs, first chan/data=%0d/%0d, expected 1 output 0/16384",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0].chan : -1,
                     (obs_q.size() > 0) ? obs_q[0].data : -1);
        end
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'd16384) begin
            n_fail++;
            $display("FAIL output_hold: out_valid=%b out_data=%0d, expected 0 and held 16384", out_valid, out_data);
        end
        tick();
        obs_q.delete();
        send(0, 0);
        wait_idle("impulse_zero");
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0].data != 0) begin
            n_fail++;
            $display("FAIL impulse_zero: got %0d outputs, first data=%0d, expected 1 output of 0",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : -1);
        end
    endtask

    task automatic test_tap_walk();
        do_reset();
        set_coefs(1);
        send(0, 32767);
        for (int i = 0; i < TAPS - 1; i++) send(0, 0);
        wait_idle("tap_walk");
        n_checks++;
        if (obs_q.size() != TAPS) begin
            n_fail++;
            $display("FAIL tap_walk_count: got %0d outputs, expected %0d", obs_q.size(), TAPS);
        end else begin
            n_checks++;
            if (obs_q[0].data != 1 || obs_q[39].data != 40 || obs_q[79].data != 80) begin
                n_fail++;
                $display("FAIL tap_walk_values: outputs 0/39/79 = %0d/%0d/%0d, expected 1/40/80",
                         obs_q[0].data, obs_q[39].data, obs_q[79].data);
            end
        end
    endtask

    task automatic test_arbitration();
        bit ok = 1'b0;
        l_valid = 1'b1; l_data = 16'sd300;
        r_valid = 1'b1; r_data = -16'sd500;
        do_reset();
        @(negedge clk);
        n_checks++;
        if (l_ready !== 1'b1 || r_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_first: l_ready=%b r_ready=%b, expected 1 0", l_ready, r_ready);
        end
        for (int i = 0; i < 120 && !ok; i++) begin
            @(negedge clk);
            ok = (acc_log.size() >= 6);
        end
        tick();
        l_valid = 1'b0;
        r_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL arb_timeout: got %0d accepts, expected 6 within 120 cycles", acc_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (acc_log[i].chan != (i % 2) ||
                    (i > 0 && acc_log[i].cyc - acc_log[i-1].cyc != longint'(LAT))) begin
                    n_fail++;
                    $display("FAIL arb_order_%0d: chan=%0d gap=%0d, expected chan=%0d gap=%0d", i,
                             acc_log[i].chan, (i > 0) ? acc_log[i].cyc - acc_log[i-1].cyc : 0,
                             i % 2, (i > 0) ? LAT : 0);
                end
            end
        end
        wait_idle("arbitration");
    endtask

    task automatic test_saturation();
        set_coefs(2);
        obs_q.delete();
        for (int i = 0; i < TAPS; i++) send(0, 32767);
        wait_idle("sat_pos");
        n_checks++;
        if (obs_q.size() != TAPS || obs_q[TAPS-1].data != 32767) begin
            n_fail++;
            $display("FAIL sat_pos: %0d outputs, last=%0d, expected %0d outputs, last 32767",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1].data : 0, TAPS);
        end
        obs_q.delete();
        for (int i = 0; i < TAPS; i++) send(0, -32768);
        wait_idle("sat_neg");
        n_checks++;
        if (obs_q.size() != TAPS || obs_q[TAPS-1].data != -32768) begin
            n_fail++;
            $display("FAIL sat_neg: %0d outputs, last=%0d, expected %0d outputs, last -32768",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1].data : 0, TAPS);
        end
    endtask

    task automatic test_channel_isolation();
        int l_seen[$];
        int r_seen[$];
        do_reset();
        set_coefs(3);   // tap0 = 32767, tap1 = 16384: outputs depend on the previous sample too
        fork
            begin
                for (int i = 0; i < 4; i++) send(0, 1000);
            end
            begin
                send(1, 16384);
                send(1, 0);
            end
        join
        wait_idle("isolation");
        foreach (obs_q[i]) begin
            if (obs_q[i].chan == 0) l_seen.push_back(obs_q[i].data);
            else                    r_seen.push_back(obs_q[i].data);
        end
        n_checks++;
        if (r_seen.size() != 2 || r_seen[0] != 16384 || r_seen[1] != 8192) begin
            n_fail++;
            $display("FAIL iso_right: %0d right outputs, first=%0d second=%0d, expected 2 outputs 16384 8192",
                     r_seen.size(), (r_seen.size() > 0) ? r_seen[0] : 0, (r_seen.size() > 1) ? r_seen[1] : 0);
        end
        n_checks++;
        if (l_seen.size() != 4 || l_seen[0] != 1000 || l_seen[1] != 1500 ||
            l_seen[2] != 1500 || l_seen[3] != 1500) begin
            n_fail++;
            $display("FAIL iso_left: %0d left outputs, first=%0d last=%0d, expected 1000 1500 1500 1500",
                     l_seen.size(), (l_seen.size() > 0) ? l_seen[0] : 0,
                     (l_seen.size() > 0) ? l_seen[l_seen.size()-1] : 0);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen = 1'b0;
        set_coefs(2);
        for (int i = 0; i < 5; i++) send(0, 100);
        wait_idle("mid_run_history");
        send(0, 7);      // now in the cnt 0 cycle
        tick();
        tick();
        tick();          // cnt 3 cycle
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (coef_addr !== 2'd3) begin
            n_fail++;
            $display("FAIL mid_run_cnt3: coef_addr=%0d when reset raised, expected 3", coef_addr);
        end
        tick();
        clear_model();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL mid_run_no_output: out_valid seen after reset, expected none");
        end
        tick();
        send(0, 16384);
        wait_idle("after_reset");
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0].data != 16384) begin
            n_fail++;
            $display("FAIL mid_run_clean: %0d outputs, first=%0d, expected 1 output of 16384",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 0);
        end
    endtask

    initial begin
        for (int k = 0; k < TAPS; k++) coef_mem[k] = '0;
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < TAPS; k++) m_line[c][k] = 0;
        test_reset();
        test_impulse();
        test_tap_walk();
        test_arbitration();
        test_saturation();
        test_channel_isolation();
        test_reset_mid_run();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d outputs never delivered, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
